// File: rtl/psr_flag_unit.sv
// CPSR/SPSR condition-flag stage: captures ALU flags, saves/restores them on
// exceptions, evaluates the ARM condition field and feeds C back as carry-in.
module psr_flag_unit #(
    parameter bit NV_PASS = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       stall,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       shifter_c,
    input  logic       s_update,
    input  logic       logical_op,
    input  logic       msr_we,
    input  logic [3:0] msr_data,
    input  logic       exc_save,
    input  logic       exc_restore,
    input  logic [3:0] cond,
    output logic [3:0] flags,
    output logic [3:0] spsr_flags,
    output logic       alu_cin,
    output logic       cond_pass,
    output logic       cond_pass_q
);

    logic [3:0] flags_q, flags_d;
    logic [3:0] spsr_q, spsr_d;
    logic       cond_pass_reg_q;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Restore outranks MSR, which outranks the ALU; logical ops keep V.
    always_comb begin
        flags_d = flags_q;
        if (exc_restore) begin
            flags_d = spsr_q;
        end else if (msr_we) begin
            flags_d = msr_data;
        end else if (s_update) begin
            if (logical_op) begin
                flags_d = {alu_n, alu_z, shifter_c, flags_q[0]};
            end else begin
                flags_d = {alu_n, alu_z, alu_c, alu_v};
            end
        end
    end

    // SPSR always takes the pre-edge CPSR, so save+restore is a swap.
    always_comb begin
        spsr_d = spsr_q;
        if (exc_save) begin
            spsr_d = flags_q;
        end
    end

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = NV_PASS;
        endcase
    end

    // An unknown stall falls to the hold branch and leaves state intact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q         <= 4'b0000;
            spsr_q          <= 4'b0000;
            cond_pass_reg_q <= 1'b0;
        end else if (stall == 1'b0) begin
            flags_q         <= flags_d;
            spsr_q          <= spsr_d;
            cond_pass_reg_q <= cond_pass;
        end
    end

    assign flags       = flags_q;
    assign spsr_flags  = spsr_q;
    assign alu_cin     = flags_q[1];
    assign cond_pass_q = cond_pass_reg_q;

endmodule

// File: tb/tb_psr_flag_unit.sv
// Bench for psr_flag_unit: directed vector table, hand sequences for reset and
// condition decode, then random traffic against a behavioural flag model.
module tb_psr_flag_unit;

    logic       clk = 1'b0;
    logic       reset_n, stall, alu_n, alu_z, alu_c, alu_v, shifter_c;
    logic       s_update, logical_op, msr_we, exc_save, exc_restore;
    logic [3:0] msr_data, cond;
    logic [3:0] flags0, spsr0, flags1, spsr1;
    logic       cin0, cp0, cpq0, cin1, cp1, cpq1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    psr_flag_unit #(.NV_PASS(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .shifter_c(shifter_c), .s_update(s_update), .logical_op(logical_op),
        .msr_we(msr_we), .msr_data(msr_data), .exc_save(exc_save),
        .exc_restore(exc_restore), .cond(cond), .flags(flags0),
        .spsr_flags(spsr0), .alu_cin(cin0), .cond_pass(cp0), .cond_pass_q(cpq0)
    );

    psr_flag_unit #(.NV_PASS(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .shifter_c(shifter_c), .s_update(s_update), .logical_op(logical_op),
        .msr_we(msr_we), .msr_data(msr_data), .exc_save(exc_save),
        .exc_restore(exc_restore), .cond(cond), .flags(flags1),
        .spsr_flags(spsr1), .alu_cin(cin1), .cond_pass(cp1), .cond_pass_q(cpq1)
    );

    // Behavioural model state
    logic [3:0] m_flags, m_spsr;
    logic       m_cpq0, m_cpq1;

    typedef struct {
        logic       st, su, lo, mw, es, er;
        logic [3:0] alu;
        logic       sc;
        logic [3:0] md, cd;
        logic [3:0] ef, esp;
        logic       ecp;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic st, logic su, logic lo, logic mw, logic es,
                                logic er, logic [3:0] alu, logic sc, logic [3:0] md,
                                logic [3:0] cd, logic [3:0] ef, logic [3:0] esp,
                                logic ecp);
        vec_t v;
        v.st = st; v.su = su; v.lo = lo; v.mw = mw; v.es = es; v.er = er;
        v.alu = alu; v.sc = sc; v.md = md; v.cd = cd;
        v.ef = ef; v.esp = esp; v.ecp = ecp;
        return v;
    endfunction

    // Even codes test a predicate, odd codes its negation; 1110/1111 are special.
    function automatic logic ref_cond(logic [3:0] f, logic [3:0] c, logic nv);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return nv;
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cy;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cy && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b0;
        endcase
        return c[0] ? !r : r;
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic set_in(vec_t v);
        stall = v.st; s_update = v.su; logical_op = v.lo; msr_we = v.mw;
        exc_save = v.es; exc_restore = v.er;
        {alu_n, alu_z, alu_c, alu_v} = v.alu;
        shifter_c = v.sc; msr_data = v.md; cond = v.cd;
    endtask

    task automatic model_reset();
        m_flags = 4'b0000; m_spsr = 4'b0000; m_cpq0 = 1'b0; m_cpq1 = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] nf, ns;
        if (!stall) begin
            m_cpq0 = ref_cond(m_flags, cond, 1'b0);
            m_cpq1 = ref_cond(m_flags, cond, 1'b1);
            ns = exc_save ? m_flags : m_spsr;
            if (exc_restore)            nf = m_spsr;
            else if (msr_we)            nf = msr_data;
            else if (s_update && logical_op) nf = {alu_n, alu_z, shifter_c, m_flags[0]};
            else if (s_update)          nf = {alu_n, alu_z, alu_c, alu_v};
            else                        nf = m_flags;
            m_flags = nf;
            m_spsr  = ns;
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all(string tag);
        chk({tag, ".flags"}, flags0, m_flags);
        chk({tag, ".spsr"}, spsr0, m_spsr);
        chk({tag, ".alu_cin"}, {3'b0, cin0}, {3'b0, m_flags[1]});
        chk({tag, ".cond_pass"}, {3'b0, cp0}, {3'b0, ref_cond(m_flags, cond, 1'b0)});
        chk({tag, ".cond_pass_q"}, {3'b0, cpq0}, {3'b0, m_cpq0});
        chk({tag, ".nv1.flags"}, flags1, m_flags);
        chk({tag, ".nv1.cond_pass"}, {3'b0, cp1}, {3'b0, ref_cond(m_flags, cond, 1'b1)});
        chk({tag, ".nv1.cond_pass_q"}, {3'b0, cpq1}, {3'b0, m_cpq1});
    endtask

    vec_t idle;
    logic [3:0] cl[5];
    logic       ce[5];

    initial begin
        idle = mk(0,0,0,0,0,0, 4'b0000, 0, 4'b0000, 4'b1110, 4'b0, 4'b0, 1'b0);
        set_in(idle);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Load flags and SPSR with ones, then reset between clock edges
        set_in(mk(0,0,0,1,0,0, 4'b0, 0, 4'b1111, 4'b1110, 4'b0, 4'b0, 1'b0));
        do_cycle();
        set_in(mk(0,0,0,0,1,0, 4'b0, 0, 4'b0000, 4'b1110, 4'b0, 4'b0, 1'b0));
        do_cycle();
        chk("pre_reset.flags", flags0, 4'b1111);
        chk("pre_reset.spsr", spsr0, 4'b1111);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset.flags", flags0, 4'b0000);
        chk("reset.spsr", spsr0, 4'b0000);
        chk("reset.alu_cin", {3'b0, cin0}, 4'b0000);
        chk("reset.cond_pass_q", {3'b0, cpq0}, 4'b0000);
        cond = 4'b1110; #1;
        chk("reset.AL", {3'b0, cp0}, 4'b0001);
        cond = 4'b0000; #1;
        chk("reset.EQ", {3'b0, cp0}, 4'b0000);
        cond = 4'b1111; #1;
        chk("reset.NV0", {3'b0, cp0}, 4'b0000);
        chk("reset.NV1", {3'b0, cp1}, 4'b0001);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // NV result registered into cond_pass_q on the next edge
        do_cycle();
        chk("nv.cpq0", {3'b0, cpq0}, 4'b0000);
        chk("nv.cpq1", {3'b0, cpq1}, 4'b0001);

        // 25-25 arithmetic update, then decode several conditions by hand
        set_in(mk(0,1,0,0,0,0, 4'b0110, 0, 4'b0, 4'b1110, 4'b0, 4'b0, 1'b0));
        do_cycle();
        chk("arith.flags", flags0, 4'b0110);
        chk("arith.alu_cin", {3'b0, cin0}, 4'b0001);
        s_update = 1'b0;
        cl = '{4'b0000, 4'b0010, 4'b1001, 4'b0001, 4'b1000};
        ce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cond = cl[i]; #1;
            chk($sformatf("arith.cond%b", cl[i]), {3'b0, cp0}, {3'b0, ce[i]});
        end

        // Directed table: each row is one clock, expectations are post-edge
        vecs[0]  = mk(0,1,0,0,0,0, 4'b0110, 0, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 1);
        vecs[1]  = mk(0,0,0,1,0,0, 4'b0000, 0, 4'b1011, 4'b0110, 4'b1011, 4'b0000, 1);
        vecs[2]  = mk(0,1,1,0,0,0, 4'b0110, 0, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 1);
        vecs[3]  = mk(0,0,0,0,1,0, 4'b0000, 0, 4'b0000, 4'b0100, 4'b0101, 4'b0101, 0);
        vecs[4]  = mk(0,0,0,1,0,0, 4'b0000, 0, 4'b1111, 4'b1110, 4'b1111, 4'b0101, 1);
        vecs[5]  = mk(0,0,0,1,0,0, 4'b0000, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0101, 0);
        vecs[6]  = mk(0,0,0,0,1,0, 4'b0000, 0, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 1);
        vecs[7]  = mk(0,0,0,1,0,0, 4'b0000, 0, 4'b0000, 4'b0011, 4'b0000, 4'b0010, 1);
        vecs[8]  = mk(0,1,0,1,0,1, 4'b0110, 0, 4'b1111, 4'b1000, 4'b0010, 4'b0010, 1);
        vecs[9]  = mk(0,1,0,1,0,0, 4'b0110, 0, 4'b1111, 4'b1101, 4'b1111, 4'b0010, 1);
        vecs[10] = mk(0,0,0,1,0,0, 4'b0000, 0, 4'b1001, 4'b1010, 4'b1001, 4'b0010, 1);
        vecs[11] = mk(0,1,0,0,1,0, 4'b0100, 0, 4'b0000, 4'b0001, 4'b0100, 4'b1001, 0);
        vecs[12] = mk(0,0,0,0,0,1, 4'b0000, 0, 4'b0000, 4'b1100, 4'b1001, 4'b1001, 1);
        vecs[13] = mk(0,0,0,1,0,0, 4'b0000, 0, 4'b0011, 4'b1011, 4'b0011, 4'b1001, 1);
        vecs[14] = mk(0,0,0,0,1,1, 4'b0000, 0, 4'b0000, 4'b1011, 4'b1001, 4'b0011, 0);
        vecs[15] = mk(1,1,0,0,0,0, 4'b0000, 0, 4'b0000, 4'b1010, 4'b1001, 4'b0011, 1);
        vecs[16] = mk(1,0,0,1,1,1, 4'b0000, 0, 4'b0110, 4'b1001, 4'b1001, 4'b0011, 1);
        vecs[17] = mk(0,0,0,0,0,0, 4'b0000, 0, 4'b0000, 4'b1111, 4'b1001, 4'b0011, 0);
        for (int i = 0; i < 18; i++) begin
            set_in(vecs[i]);
            do_cycle();
            chk($sformatf("vec%0d.flags", i), flags0, vecs[i].ef);
            chk($sformatf("vec%0d.spsr", i), spsr0, vecs[i].esp);
            chk($sformatf("vec%0d.cond_pass", i), {3'b0, cp0}, {3'b0, vecs[i].ecp});
            check_all($sformatf("vec%0d", i));
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 4) == 0);
            s_update    = $urandom_range(0, 1);
            logical_op  = $urandom_range(0, 1);
            msr_we      = ($urandom_range(0, 5) == 0);
            exc_save    = ($urandom_range(0, 5) == 0);
            exc_restore = ($urandom_range(0, 5) == 0);
            {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
            shifter_c   = $urandom_range(0, 1);
            msr_data    = 4'($urandom);
            cond        = 4'($urandom);
            #1;
            chk($sformatf("rnd%0d.pre_cond_pass", i), {3'b0, cp0},
                {3'b0, ref_cond(m_flags, cond, 1'b0)});
            do_cycle();
            check_all($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/psr_flag_unit.md
Name: psr_flag_unit

Overview:
- Condition-flag register stage directly downstream of the ALU.
- Captures the ALU's N/Z/C/V results into the architectural CPSR flag bits on flag-setting instructions.
- Keeps a saved copy (SPSR flags) for exception entry and return.
- Evaluates the 4-bit ARM condition field against the current flags.
- Feeds the stored C flag back to the ALU carry-in, closing the ADC/SBC/RSC loop.

Parameters:
- NV_PASS, 0, condition result for cond=4'b1111 (0 = never execute, 1 = treat as always).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- stall  input  1  holds all state this cycle when 1
- alu_n  input  1  ALU N output
- alu_z  input  1  ALU ZERO output
- alu_c  input  1  ALU COUT output
- alu_v  input  1  ALU V output
- shifter_c  input  1  barrel-shifter carry-out, used for logical ops
- s_update  input  1  instruction S bit: commit flags at the end of this cycle
- logical_op  input  1  1 = logical opcode (AND/EOR/TST/TEQ/ORR/MOV/BIC/MVN)
- msr_we  input  1  direct flag write (MSR flags field)
- msr_data  input  4  {N,Z,C,V} for MSR
- exc_save  input  1  copy CPSR flags into SPSR flags
- exc_restore  input  1  copy SPSR flags into CPSR flags
- cond  input  4  instruction condition field [31:28]
- flags  output  4  current CPSR {N,Z,C,V}
- spsr_flags  output  4  saved {N,Z,C,V}
- alu_cin  output  1  equals flags C bit; drives ALU CIN
- cond_pass  output  1  combinational condition result on current flags
- cond_pass_q  output  1  cond_pass registered, for the writeback stage

Behaviour:
- Reset (reset_n low, asynchronous):
  - flags = 4'b0000, spsr_flags = 4'b0000, cond_pass_q = 0.
  - alu_cin = 0.
  - cond_pass then reflects zero flags, e.g. cond=EQ gives 0.
- Reset asserted mid-operation clears all state immediately, regardless of clk.
- stall=1: flags, spsr_flags and cond_pass_q all hold. cond_pass still tracks cond combinationally.
- CPSR update, evaluated each rising edge when stall=0, first match wins:
  1. exc_restore: flags <= spsr_flags.
  2. msr_we: flags <= msr_data.
  3. s_update with logical_op=0: flags <= {alu_n, alu_z, alu_c, alu_v}.
  4. s_update with logical_op=1: N <= alu_n, Z <= alu_z, C <= shifter_c, V unchanged.
  5. Otherwise: hold.
- SPSR update:
  - exc_save: spsr_flags <= pre-edge flags value.
  - exc_save and any CPSR write in the same cycle: SPSR receives the old flags, CPSR receives the new value.
  - exc_save and exc_restore together: swap (SPSR <= old CPSR, CPSR <= old SPSR).
- Flag writes are not gated by cond_pass. The decoder deasserts s_update for failed instructions.
- Latency:
  - Flags written at edge k are visible on flags, alu_cin and cond_pass after edge k.
  - cond_pass_q at edge k+1 equals cond_pass before edge k+1.
  - There is no internal bypass. A back-to-back dependent instruction sees the committed value one cycle later.
- Condition decode for cond_pass (N,Z,C,V = flags):
  - 0000 EQ Z
  - 0001 NE !Z
  - 0010 CS C
  - 0011 CC !C
  - 0100 MI N
  - 0101 PL !N
  - 0110 VS V
  - 0111 VC !V
  - 1000 HI C&!Z
  - 1001 LS !C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT !Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 NV_PASS
- No X propagation: an undefined input combination must not corrupt held state.

Test Plan:
- Reset: drive reset_n=0 mid-clock with flags=4'b1111 -> flags=0000, spsr_flags=0000, alu_cin=0 immediately; cond=AL gives cond_pass=1, cond=EQ gives 0.
- Arithmetic update: ALU computes 25-25 with s_update=1, logical_op=0, alu={0,1,1,0} -> after edge flags=0110, alu_cin=1; EQ, CS and LS pass; NE and HI fail.
- Logical update: start from flags=1011, s_update=1, logical_op=1, alu_n=0, alu_z=1, shifter_c=0 -> flags=0101 (V kept at 1).
- Priority: exc_restore, msr_we (msr_data=1111) and s_update all in one cycle with spsr_flags=0010 -> flags=0010. Next cycle msr_we and s_update -> flags=1111.
- Exception save/restore: flags=1001, exc_save with s_update loading 0100 -> spsr_flags=1001, flags=0100. Later exc_restore -> flags=1001. exc_save together with exc_restore -> values swap.
- Stall, GE/LT and cond_pass_q: flags=1001 (N=V) -> GE=1, LT=0, GT=1. Assert stall with s_update loading 0000 -> flags unchanged. cond_pass_q lags cond_pass by exactly one unstalled edge. cond=1111 yields NV_PASS for both parameter values.
